// File: rtl/psx_bus_receiver_pkg.sv
// Shared definitions for the PSX controller-bus receiver: byte geometry,
// FSM state encodings and the standard pad command bytes.
package psx_bus_receiver_pkg;

   localparam int PSX_BYTE_BITS = 8;
   localparam int PSX_BIT_CNT_W = $clog2(PSX_BYTE_BITS);

   localparam logic [7:0] PSX_CMD_START = 8'h01;
   localparam logic [7:0] PSX_CMD_POLL  = 8'h42;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ERROR  = 2'd2
   } psx_state_e;

endpackage

// File: rtl/psx_bus_receiver_sync_edge.sv
// psx_sync_edge: two-flop synchronizer for one asynchronous pin, with the
// synchronized level and single-cycle rise/fall pulses.
module psx_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchronizer chain plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_r <= RESET_VAL;
         sync_r <= RESET_VAL;
         prev_r <= RESET_VAL;
      end else begin
         meta_r <= pin;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign level = sync_r;
   assign rise  = sync_r & ~prev_r;
   assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/psx_bus_receiver.sv
// Passive PSX controller-bus sniffer: reassembles LSB-first CMD/DAT byte pairs
// and strobes each with its packet position. PSX_ACK_MONITOR_EN adds ACK tracking.
module psx_bus_receiver
   import psx_bus_receiver_pkg::*;
#(
   parameter int TIMEOUT_BITS = 10,
   parameter int INDEX_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  psx_att_n,
   input  logic                  psx_clk,
   input  logic                  psx_cmd,
   input  logic                  psx_dat,
`ifdef PSX_ACK_MONITOR_EN
   input  logic                  psx_ack_n,
`endif
   output logic                  byte_strobe,
   output logic [7:0]            cmd_byte,
   output logic [7:0]            dat_byte,
   output logic [INDEX_BITS-1:0] byte_index,
   output logic                  packet_start,
   output logic                  packet_end,
   output logic                  frame_error,
   output logic                  ack_seen
);

   localparam logic [PSX_BIT_CNT_W-1:0] BIT_LAST  = PSX_BIT_CNT_W'(PSX_BYTE_BITS - 1);
   localparam logic [TIMEOUT_BITS-1:0]  STALL_MAX = {TIMEOUT_BITS{1'b1}};
   localparam logic [INDEX_BITS-1:0]    INDEX_MAX = {INDEX_BITS{1'b1}};

   logic att_level_s, att_rise_s, att_fall_s;
   logic clk_level_s, clk_rise_s, clk_fall_s;
   logic cmd_level_s, cmd_rise_s, cmd_fall_s;
   logic dat_level_s, dat_rise_s, dat_fall_s;
   logic ack_low_s;
   logic unused_edges_s;

   psx_sync_edge #(.RESET_VAL(1'b1)) u_sync_att (.clk(clk), .reset_n(reset_n), .pin(psx_att_n),
      .level(att_level_s), .rise(att_rise_s), .fall(att_fall_s));
   psx_sync_edge #(.RESET_VAL(1'b1)) u_sync_clk (.clk(clk), .reset_n(reset_n), .pin(psx_clk),
      .level(clk_level_s), .rise(clk_rise_s), .fall(clk_fall_s));
   psx_sync_edge #(.RESET_VAL(1'b0)) u_sync_cmd (.clk(clk), .reset_n(reset_n), .pin(psx_cmd),
      .level(cmd_level_s), .rise(cmd_rise_s), .fall(cmd_fall_s));
   psx_sync_edge #(.RESET_VAL(1'b0)) u_sync_dat (.clk(clk), .reset_n(reset_n), .pin(psx_dat),
      .level(dat_level_s), .rise(dat_rise_s), .fall(dat_fall_s));

`ifdef PSX_ACK_MONITOR_EN
   logic ack_level_s, ack_rise_s, ack_fall_s;
   psx_sync_edge #(.RESET_VAL(1'b1)) u_sync_ack (.clk(clk), .reset_n(reset_n), .pin(psx_ack_n),
      .level(ack_level_s), .rise(ack_rise_s), .fall(ack_fall_s));
   assign ack_low_s      = ~ack_level_s;
   assign unused_edges_s = ^{att_rise_s, att_fall_s, clk_level_s, cmd_rise_s, cmd_fall_s,
                             dat_rise_s, dat_fall_s, ack_rise_s, ack_fall_s};
`else
   assign ack_low_s      = 1'b0;
   assign unused_edges_s = ^{att_rise_s, att_fall_s, clk_level_s, cmd_rise_s, cmd_fall_s,
                             dat_rise_s, dat_fall_s};
`endif

   psx_state_e                state_r, state_next_s;
   logic [PSX_BIT_CNT_W-1:0]  bits_r, bits_next_s;
   logic [TIMEOUT_BITS-1:0]   stall_r, stall_next_s;
   logic [INDEX_BITS-1:0]     index_r, index_next_s;
   logic [7:0]                shift_cmd_r, shift_cmd_next_s, shift_dat_r, shift_dat_next_s;
   logic [7:0]                cmd_byte_r, cmd_byte_next_s, dat_byte_r, dat_byte_next_s;
   logic [INDEX_BITS-1:0]     byte_index_r, byte_index_next_s;
   logic                      strobe_r, strobe_next_s;
   logic                      start_r, start_next_s, end_r, end_next_s, ferr_r, ferr_next_s;
   logic                      ack_flag_r, ack_flag_next_s, ack_seen_r, ack_seen_next_s;

   // Next-state and output decode; ATT release outranks any CLK edge in the same cycle.
   always_comb begin
      state_next_s      = state_r;
      bits_next_s       = bits_r;
      stall_next_s      = '0;
      index_next_s      = index_r;
      shift_cmd_next_s  = shift_cmd_r;
      shift_dat_next_s  = shift_dat_r;
      cmd_byte_next_s   = cmd_byte_r;
      dat_byte_next_s   = dat_byte_r;
      byte_index_next_s = byte_index_r;
      strobe_next_s     = 1'b0;
      start_next_s      = 1'b0;
      end_next_s        = 1'b0;
      ferr_next_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!att_level_s) begin
               state_next_s = ST_ACTIVE;
               start_next_s = 1'b1;
               index_next_s = '0;
               bits_next_s  = '0;
            end else begin
               bits_next_s  = '0;
            end
         end
         ST_ACTIVE: begin
            if (att_level_s) begin
               state_next_s = ST_IDLE;
               end_next_s   = 1'b1;
            end else if (clk_rise_s) begin
               shift_cmd_next_s = {cmd_level_s, shift_cmd_r[7:1]};
               shift_dat_next_s = {dat_level_s, shift_dat_r[7:1]};
               if (bits_r == BIT_LAST) begin
                  strobe_next_s     = 1'b1;
                  cmd_byte_next_s   = shift_cmd_next_s;
                  dat_byte_next_s   = shift_dat_next_s;
                  byte_index_next_s = index_r;
                  bits_next_s       = '0;
                  index_next_s      = (index_r == INDEX_MAX) ? index_r : index_r + 1'b1;
               end else begin
                  bits_next_s = bits_r + 1'b1;
               end
            end else if ((bits_r != '0) && !clk_fall_s) begin
               if (stall_r == STALL_MAX) begin
                  state_next_s = ST_ERROR;
                  ferr_next_s  = 1'b1;
               end else begin
                  stall_next_s = stall_r + 1'b1;
               end
            end else begin
               stall_next_s = '0;
            end
         end
         ST_ERROR: begin
            if (att_level_s) begin
               state_next_s = ST_IDLE;
               end_next_s   = 1'b1;
            end else begin
               state_next_s = ST_ERROR;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      ack_flag_next_s = strobe_r ? 1'b0 : (ack_flag_r | ack_low_s);
      ack_seen_next_s = strobe_next_s & ack_flag_r;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         bits_r       <= '0;
         stall_r      <= '0;
         index_r      <= '0;
         shift_cmd_r  <= 8'h00;
         shift_dat_r  <= 8'h00;
         cmd_byte_r   <= 8'h00;
         dat_byte_r   <= 8'h00;
         byte_index_r <= '0;
         strobe_r     <= 1'b0;
         start_r      <= 1'b0;
         end_r        <= 1'b0;
         ferr_r       <= 1'b0;
         ack_flag_r   <= 1'b0;
         ack_seen_r   <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         bits_r       <= bits_next_s;
         stall_r      <= stall_next_s;
         index_r      <= index_next_s;
         shift_cmd_r  <= shift_cmd_next_s;
         shift_dat_r  <= shift_dat_next_s;
         cmd_byte_r   <= cmd_byte_next_s;
         dat_byte_r   <= dat_byte_next_s;
         byte_index_r <= byte_index_next_s;
         strobe_r     <= strobe_next_s;
         start_r      <= start_next_s;
         end_r        <= end_next_s;
         ferr_r       <= ferr_next_s;
         ack_flag_r   <= ack_flag_next_s;
         ack_seen_r   <= ack_seen_next_s;
      end
   end

   assign byte_strobe  = strobe_r;
   assign cmd_byte     = cmd_byte_r;
   assign dat_byte     = dat_byte_r;
   assign byte_index   = byte_index_r;
   assign packet_start = start_r;
   assign packet_end   = end_r;
   assign frame_error  = ferr_r;
   assign ack_seen     = ack_seen_r;

endmodule

// File: tb/tb_psx_bus_receiver.sv
// Scoreboard bench for psx_bus_receiver (INDEX_BITS=2 so index saturation is reachable).
module tb_psx_bus_receiver;

   localparam int IB = 2;
`ifdef PSX_ACK_MONITOR_EN
   localparam logic ACK_EXP = 1'b1;
`else
   localparam logic ACK_EXP = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]    cmd;
      logic [7:0]    dat;
      logic [IB-1:0] idx;
      logic          ack;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic psx_att_n = 1'b1;
   logic psx_clk = 1'b1;
   logic psx_cmd = 1'b0;
   logic psx_dat = 1'b0;
   logic psx_ack_n = 1'b1;
   logic byte_strobe, packet_start, packet_end, frame_error, ack_seen;
   logic [7:0] cmd_byte, dat_byte;
   logic [IB-1:0] byte_index;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;
   int ps_cnt = 0;
   int pe_cnt = 0;
   int fe_cnt = 0;

   psx_bus_receiver #(.TIMEOUT_BITS(10), .INDEX_BITS(IB)) dut (
      .clk(clk), .reset_n(reset_n), .psx_att_n(psx_att_n), .psx_clk(psx_clk),
      .psx_cmd(psx_cmd), .psx_dat(psx_dat),
`ifdef PSX_ACK_MONITOR_EN
      .psx_ack_n(psx_ack_n),
`endif
      .byte_strobe(byte_strobe), .cmd_byte(cmd_byte), .dat_byte(dat_byte),
      .byte_index(byte_index), .packet_start(packet_start), .packet_end(packet_end),
      .frame_error(frame_error), .ack_seen(ack_seen)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each strobe and counts the event pulses.
   always @(negedge clk) begin
      if (reset_n) begin
         if (packet_start) ps_cnt++;
         if (packet_end) pe_cnt++;
         if (frame_error) fe_cnt++;
         if (byte_strobe) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("cmd_byte", cmd_byte, e.cmd);
               check("dat_byte", dat_byte, e.dat);
               check("byte_index", byte_index, e.idx);
               check("ack_seen", ack_seen, e.ack);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] c, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         psx_clk = 1'b0; psx_cmd = c[i]; psx_dat = d[i];
         wait_cyc(4);
         psx_clk = 1'b1;
         wait_cyc(4);
      end
   endtask

   task automatic send_exp(input logic [7:0] c, input logic [7:0] d,
                           input logic [IB-1:0] idx, input logic ack);
      exp_t e;
      e.cmd = c; e.dat = d; e.idx = idx; e.ack = ack;
      exp_q.push_back(e);
      send_bits(c, d, 8);
   endtask

   logic [7:0]    p_cmd [6] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0]    p_dat [6] = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hA5, 8'h3C};
   logic [IB-1:0] p_idx [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(2);
      @(negedge clk);
      check("rst_strobe", byte_strobe, 0);
      check("rst_cmd", cmd_byte, 0);
      check("rst_dat", dat_byte, 0);
      check("rst_index", byte_index, 0);
      check("rst_start", packet_start, 0);
      check("rst_end", packet_end, 0);
      check("rst_ferr", frame_error, 0);
      check("rst_ack", ack_seen, 0);
      wait_cyc(2);

      // Poll packet with ACK pulse after byte 0 only.
      psx_att_n = 1'b0;
      wait_cyc(8);
      send_exp(8'h01, 8'hFF, 2'd0, 1'b0);
      wait_cyc(10);
      psx_ack_n = 1'b0;
      wait_cyc(3);
      psx_ack_n = 1'b1;
      wait_cyc(10);
      send_exp(8'h42, 8'h41, 2'd1, ACK_EXP);
      send_exp(8'h00, 8'h5A, 2'd2, 1'b0);
      wait_cyc(8);
      psx_att_n = 1'b1;
      wait_cyc(10);
      check("t1_start_cnt", ps_cnt, 1);
      check("t1_end_cnt", pe_cnt, 1);

      // Six-byte packet restarts at index 0 and saturates.
      psx_att_n = 1'b0;
      wait_cyc(8);
      for (int i = 0; i < 6; i++) send_exp(p_cmd[i], p_dat[i], p_idx[i], 1'b0);
      wait_cyc(8);
      psx_att_n = 1'b1;
      wait_cyc(10);
      check("t4_start_cnt", ps_cnt, 2);
      check("t4_end_cnt", pe_cnt, 2);

      // Mid-byte stall: frame_error once, later edges ignored.
      psx_att_n = 1'b0;
      wait_cyc(8);
      send_bits(8'h55, 8'hAA, 3);
      wait_cyc(1100);
      check("t3_ferr_cnt", fe_cnt, 1);
      send_bits(8'h42, 8'h41, 8);
      wait_cyc(8);
      psx_att_n = 1'b1;
      wait_cyc(10);
      check("t3_ferr_after", fe_cnt, 1);
      check("t3_end_cnt", pe_cnt, 3);

      // ATT release coincident with the 8th edge drops the byte.
      psx_att_n = 1'b0;
      wait_cyc(8);
      send_bits(8'hC3, 8'h3C, 7);
      psx_clk = 1'b0; psx_cmd = 1'b1; psx_dat = 1'b0;
      wait_cyc(4);
      psx_clk = 1'b1; psx_att_n = 1'b1;
      wait_cyc(20);
      check("t5_start_cnt", ps_cnt, 4);
      check("t5_end_cnt", pe_cnt, 4);

      // Fresh packet after the dropped byte starts clean.
      psx_att_n = 1'b0;
      wait_cyc(8);
      send_exp(8'h42, 8'h5A, 2'd0, 1'b0);
      wait_cyc(8);
      psx_att_n = 1'b1;
      wait_cyc(20);
      check("final_end_cnt", pe_cnt, 5);
      check("final_ferr_cnt", fe_cnt, 1);
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
